// File: rtl/bch_correct_stage.sv
// BCH(15,7) t=2 correction stage: aligns the received word with the Chien search result,
// applies the correction, flags uncorrectable words and extracts the 7-bit message.
// Optional statistics counters are built when BCH_STATS_EN is defined.
module bch_correct_stage #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [14:0]       codeword_in,
  input  logic [3:0]        lambda1,
  input  logic [3:0]        lambda2,
  input  logic [14:0]       error_vector,
  input  logic              error_found,
  output logic              out_valid,
  output logic [14:0]       codeword_out,
  output logic [6:0]        data_out,
  output logic [1:0]        err_count,
  output logic              err_uncorr
`ifdef BCH_STATS_EN
  ,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stat_words,
  output logic [CNT_W-1:0]  stat_corr,
  output logic [CNT_W-1:0]  stat_uncorr
`endif
);

  logic        dl_vld_q [LATENCY];
  logic [14:0] dl_cw_q  [LATENCY];
  logic [3:0]  dl_l1_q  [LATENCY];
  logic [3:0]  dl_l2_q  [LATENCY];

  logic        dly_vld;
  logic [14:0] dly_cw;
  logic [3:0]  dly_l1;
  logic [3:0]  dly_l2;
  logic [1:0]  deg;
  logic [3:0]  roots;
  logic        uncorr;
  logic [14:0] cw_fix;
  logic [1:0]  cnt_fix;

  // Delay line matching the Chien stage latency; shifts every cycle, no backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_vld_q[i] <= 1'b0;
        dl_cw_q[i]  <= '0;
        dl_l1_q[i]  <= '0;
        dl_l2_q[i]  <= '0;
      end
    end else begin
      dl_vld_q[0] <= in_valid;
      dl_cw_q[0]  <= codeword_in;
      dl_l1_q[0]  <= lambda1;
      dl_l2_q[0]  <= lambda2;
      for (int i = 1; i < LATENCY; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_cw_q[i]  <= dl_cw_q[i-1];
        dl_l1_q[i]  <= dl_l1_q[i-1];
        dl_l2_q[i]  <= dl_l2_q[i-1];
      end
    end
  end

  assign dly_vld = dl_vld_q[LATENCY-1];
  assign dly_cw  = dl_cw_q[LATENCY-1];
  assign dly_l1  = dl_l1_q[LATENCY-1];
  assign dly_l2  = dl_l2_q[LATENCY-1];

  // Decide: locator degree must equal the number of Chien roots, and error_found must agree.
  always_comb begin
    roots = '0;
    for (int i = 0; i < 15; i++) begin
      roots = roots + {3'b000, error_vector[i]};
    end
    if (dly_l2 != 4'h0)      deg = 2'd2;
    else if (dly_l1 != 4'h0) deg = 2'd1;
    else                     deg = 2'd0;
    uncorr  = ({2'b00, deg} != roots) | (error_found != (roots != 4'h0));
    cw_fix  = uncorr ? dly_cw : (dly_cw ^ error_vector);
    cnt_fix = uncorr ? 2'd0 : roots[1:0];
  end

  // Output register; data fields hold their last value across bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      codeword_out <= '0;
      err_count    <= '0;
      err_uncorr   <= 1'b0;
    end else begin
      out_valid <= dly_vld;
      if (dly_vld) begin
        codeword_out <= cw_fix;
        err_count    <= cnt_fix;
        err_uncorr   <= uncorr;
      end
    end
  end

  assign data_out = codeword_out[14:8];

`ifdef BCH_STATS_EN
  // Saturating statistics, counted on each out_valid; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_words  <= '0;
      stat_corr   <= '0;
      stat_uncorr <= '0;
    end else if (clr_stats) begin
      stat_words  <= '0;
      stat_corr   <= '0;
      stat_uncorr <= '0;
    end else if (out_valid) begin
      if (stat_words != '1) stat_words <= stat_words + CNT_W'(1);
      if (err_count != 2'd0 && stat_corr != '1) stat_corr <= stat_corr + CNT_W'(1);
      if (err_uncorr && stat_uncorr != '1) stat_uncorr <= stat_uncorr + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bch_correct_stage.sv
// Self-checking bench for bch_correct_stage: table vectors, random stream, mid-stream reset
// and (with BCH_STATS_EN) saturating statistics.
module tb_bch_correct_stage;

  localparam int unsigned LAT = 2;
`ifdef BCH_STATS_EN
  localparam int unsigned CW = 2;
`else
  localparam int unsigned CW = 16;
`endif

  logic        clk, rst, in_valid, error_found;
  logic [14:0] codeword_in, error_vector, codeword_out;
  logic [3:0]  lambda1, lambda2;
  logic        out_valid, err_uncorr;
  logic [6:0]  data_out;
  logic [1:0]  err_count;
`ifdef BCH_STATS_EN
  logic          clr_stats;
  logic [CW-1:0] stat_words, stat_corr, stat_uncorr;
`endif

  bch_correct_stage #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .codeword_in(codeword_in),
    .lambda1(lambda1), .lambda2(lambda2), .error_vector(error_vector),
    .error_found(error_found), .out_valid(out_valid), .codeword_out(codeword_out),
    .data_out(data_out), .err_count(err_count), .err_uncorr(err_uncorr)
`ifdef BCH_STATS_EN
    , .clr_stats(clr_stats), .stat_words(stat_words), .stat_corr(stat_corr),
    .stat_uncorr(stat_uncorr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] cw; logic [3:0] l1; logic [3:0] l2; logic [14:0] ev; logic ef;
    logic [14:0] exp_cw; logic [1:0] exp_cnt; logic exp_unc;
  } vec_t;
  typedef struct { logic [14:0] cw; logic [1:0] cnt; logic unc; int due; } exp_t;

  vec_t        tbl [11];
  exp_t        expq [$];
  logic [14:0] evq [$];
  logic        efq [$];
  int checks = 0, errors = 0, pulses = 0, pushes = 0, dropped = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Chien-stage stand-in: error_vector/error_found for a word appear LAT cycles after it.
  task automatic prime();
    evq.delete(); efq.delete();
    repeat (LAT) begin
      evq.push_back(15'($urandom)); efq.push_back(1'($urandom));
    end
  endtask

  task automatic step(input logic v, input logic [14:0] cw, input logic [3:0] l1,
                      input logic [3:0] l2, input logic [14:0] ev, input logic ef,
                      input logic [14:0] ecw, input logic [1:0] ecnt, input logic eunc);
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; codeword_in = cw; lambda1 = l1; lambda2 = l2;
    evq.push_back(v ? ev : 15'($urandom));
    efq.push_back(v ? ef : 1'($urandom));
    error_vector = evq.pop_front();
    error_found  = efq.pop_front();
    if (v) begin
      e.cw = ecw; e.cnt = ecnt; e.unc = eunc; e.due = cyc + LAT + 1;
      expq.push_back(e);
      pushes++;
    end
  endtask

  task automatic bubble();
    step(1'b0, 15'($urandom), 4'($urandom), 4'($urandom), 15'h0, 1'b0, 15'h0, 2'd0, 1'b0);
  endtask

  task automatic tvec(input int i);
    step(1'b1, tbl[i].cw, tbl[i].l1, tbl[i].l2, tbl[i].ev, tbl[i].ef,
         tbl[i].exp_cw, tbl[i].exp_cnt, tbl[i].exp_unc);
  endtask

  // Random word with a self-computed expectation from the decoding rule.
  task automatic rvec(input logic v);
    logic [14:0] cw, ev, ecw;
    logic [3:0] l1, l2;
    logic ef, unc;
    int deg, roots, nb;
    cw = 15'($urandom);
    l1 = 4'($urandom);
    l2 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    nb = $urandom_range(0, 3);
    ev = '0;
    for (int k = 0; k < nb; k++) ev[$urandom_range(0, 14)] = 1'b1;
    roots = $countones(ev);
    ef = ($urandom_range(0, 7) == 0) ? (roots == 0) : (roots != 0);
    deg = (l2 != 0) ? 2 : (l1 != 0) ? 1 : 0;
    unc = (roots != deg) || (ef != (roots != 0));
    ecw = unc ? cw : (cw ^ ev);
    step(v, cw, l1, l2, ev, ef, ecw, unc ? 2'd0 : 2'(roots), unc);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest outstanding word, on time.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      exp_t e;
      pulses++;
      if (expq.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        e = expq.pop_front();
        chk("codeword_out", 32'(codeword_out), 32'(e.cw));
        chk("data_out", 32'(data_out), 32'(e.cw[14:8]));
        chk("err_count", 32'(err_count), 32'(e.cnt));
        chk("err_uncorr", 32'(err_uncorr), 32'(e.unc));
        chk("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    int base;
    bit seen;
    tbl[0]  = '{15'h0000, 4'h0, 4'h0, 15'h0000, 1'b0, 15'h0000, 2'd0, 1'b0};
    tbl[1]  = '{15'h0001, 4'h1, 4'h0, 15'h0001, 1'b1, 15'h0000, 2'd1, 1'b0};
    tbl[2]  = '{15'h4100, 4'h3, 4'h5, 15'h4100, 1'b1, 15'h0000, 2'd2, 1'b0};
    tbl[3]  = '{15'h1234, 4'h2, 4'h7, 15'h0008, 1'b1, 15'h1234, 2'd0, 1'b1};
    tbl[4]  = '{15'h0005, 4'h1, 4'h0, 15'h0004, 1'b0, 15'h0005, 2'd0, 1'b1};
    tbl[5]  = '{15'h7fff, 4'h0, 4'h0, 15'h0010, 1'b1, 15'h7fff, 2'd0, 1'b1};
    tbl[6]  = '{15'h0000, 4'h1, 4'h2, 15'h0007, 1'b1, 15'h0000, 2'd0, 1'b1};
    tbl[7]  = '{15'h5a5a, 4'h9, 4'h0, 15'h4000, 1'b1, 15'h1a5a, 2'd1, 1'b0};
    tbl[8]  = '{15'h2f00, 4'h4, 4'h8, 15'h0101, 1'b1, 15'h2e01, 2'd2, 1'b0};
    tbl[9]  = '{15'h6b3c, 4'h0, 4'h0, 15'h0000, 1'b0, 15'h6b3c, 2'd0, 1'b0};
    tbl[10] = '{15'h0011, 4'h0, 4'h0, 15'h0000, 1'b1, 15'h0011, 2'd0, 1'b1};

    rst = 1'b0; in_valid = 1'b0; codeword_in = '0; lambda1 = '0; lambda2 = '0;
    error_vector = '0; error_found = 1'b0;
`ifdef BCH_STATS_EN
    clr_stats = 1'b0;
`endif
    prime();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_codeword_out", 32'(codeword_out), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_err_count", 32'(err_count), 32'd0);
    chk("reset_err_uncorr", 32'(err_uncorr), 32'd0);
    rst = 1'b1;

    // 8 back-to-back words, a bubble, then the rest of the table.
    for (int i = 0; i < 8; i++) tvec(i);
    bubble();
    for (int i = 8; i < 11; i++) tvec(i);
    for (int i = 0; i < 40; i++) rvec($urandom_range(0, 3) != 0);
    repeat (LAT + 3) bubble();
    chk("drain_main", 32'(expq.size()), 32'd0);

    // Reset with words in flight: outputs clear, nothing stale afterwards.
    tvec(7); tvec(8); tvec(9);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_codeword_out", 32'(codeword_out), 32'd0);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_err_uncorr", 32'(err_uncorr), 32'd0);
    dropped = expq.size();
    expq.delete();
    prime();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    base = pulses;
    repeat (LAT + 4) bubble();
    chk("no_stale_out_valid", 32'(pulses), 32'(base));

    // Recovery after reset.
    tvec(1); tvec(2);
    for (int i = 0; i < 20 && expq.size() != 0; i++) bubble();
    chk("drain_after_reset", 32'(expq.size()), 32'd0);
    chk("pulse_count", 32'(pulses), 32'(pushes - dropped));

`ifdef BCH_STATS_EN
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("stats_reset_words", 32'(stat_words), 32'd0);
    prime();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) tvec(3);
    repeat (LAT + 4) bubble();
    chk("stat_uncorr_sat", 32'(stat_uncorr), 32'd3);
    chk("stat_words_sat", 32'(stat_words), 32'd3);
    chk("stat_corr_zero", 32'(stat_corr), 32'd0);
    tvec(1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      bubble();
      if (out_valid) seen = 1'b1;
    end
    chk("stats_out_valid_seen", 32'(seen), 32'd1);
    clr_stats = 1'b1;
    bubble();
    clr_stats = 1'b0;
    chk("clr_words", 32'(stat_words), 32'd0);
    chk("clr_corr", 32'(stat_corr), 32'd0);
    chk("clr_uncorr", 32'(stat_uncorr), 32'd0);
    repeat (LAT + 2) bubble();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
